alu_addsub_seq: RTL

Multi-cycle 64-bit add/subtract sequencer built around one shared adder_16bit slice. It accepts an operation over a valid/ready handshake and runs the slice once per cycle, least-significant first, chaining the carry through a register. It returns the result and flags over a second valid/ready handshake. It sits in the ALU as the area-reduced alternative to the full adder_64bit ripple path.

---
 rtl/alu_addsub_seq.sv | 126 ++++++++++++
 1 files changed

// File: rtl/alu_addsub_seq.sv
// Multi-cycle add/subtract sequencer. One shared adder slice is evaluated per cycle,
// least-significant slice first, with the carry chained through a register.

module adder_16bit #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// state | meaning
// IDLE  | waiting for a request; in_ready high
// RUN   | one slice added per cycle, index idx
// DONE  | result and flags presented until out_ready
module alu_addsub_seq #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic              carry;
    logic [IDXW-1:0]   idx;

    logic [SLICE-1:0]  a_s;
    logic [SLICE-1:0]  b_s;
    logic [SLICE-1:0]  s_sum;
    logic              s_cout;
    logic [WIDTH-1:0]  nres;

    // Slice operands come only from the registered copies, never from the ports.
    always_comb begin
        a_s  = '0;
        b_s  = '0;
        nres = result;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx == IDXW'(i)) begin
                a_s = a_r[i*SLICE +: SLICE];
                b_s = b_r[i*SLICE +: SLICE];
                nres[i*SLICE +: SLICE] = s_sum;
            end
        end
    end

    adder_16bit #(.W(SLICE)) u_slice (
        .a    (a_s),
        .b    (b_s),
        .cin  (carry),
        .sum  (s_sum),
        .cout (s_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        carry <= sub;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    result <= nres;
                    carry  <= s_cout;
                    if (idx == LAST) begin
                        idx      <= '0;
                        cout     <= s_cout;
                        // b_r holds the effective (possibly inverted) operand, so this covers sub too
                        overflow <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                    (nres[WIDTH-1] != a_r[WIDTH-1]);
                        zero     <= (nres == '0);
                        state    <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

endmodule
